// File: rtl/fork_join_ctrl_if.sv
// Command and worker-side signals of the fork/join sequencer.
// All handshakes are single-cycle pulses (go, wrk_start, wrk_done, cont_start, cont_done); there is no ready/backpressure.
interface fork_join_ctrl_if #(
    parameter int N_WRK = 2,
    parameter int CNT_W = 16
);
    logic             go;
    logic [1:0]       mode;
    logic [N_WRK-1:0] en;
    logic [CNT_W-1:0] timeout_lim;
    logic [N_WRK-1:0] wrk_start;
    logic [N_WRK-1:0] wrk_done;
    logic             cont_start;
    logic             cont_done;
    logic             busy;
    logic [3:0]       first_id;
    logic [CNT_W-1:0] elapsed;
    logic             timeout_err;

    // master: command source together with the worker and continuation engines
    modport master (
        output go, mode, en, timeout_lim, wrk_done, cont_done,
        input  wrk_start, cont_start, busy, first_id, elapsed, timeout_err
    );

    modport slave (
        input  go, mode, en, timeout_lim, wrk_done, cont_done,
        output wrk_start, cont_start, busy, first_id, elapsed, timeout_err
    );
endinterface

// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: launches enabled workers, waits for the selected join
// condition, fires one continuation job, then drains outstanding workers.
module fork_join_ctrl #(
    parameter int N_WRK = 2,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    fork_join_ctrl_if.slave bus,
    output logic [2:0]      dbg_state
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FORK  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CONT  = 3'd3;
    localparam logic [2:0] S_WCONT = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    localparam logic [1:0] M_ANY  = 2'b01;
    localparam logic [1:0] M_NONE = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state;
    logic [1:0]       mode_q;
    logic [N_WRK-1:0] en_q;
    logic [CNT_W-1:0] lim_q;
    logic [N_WRK-1:0] pend;
    logic [N_WRK-1:0] done_mask;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] elapsed_q;
    logic [N_WRK-1:0] wrk_start_q;
    logic             cont_start_q;
    logic             busy_q;
    logic             timeout_err_q;
    logic [3:0]       first_id_q;

    logic             tracking;
    logic [N_WRK-1:0] done_hit;
    logic [N_WRK-1:0] pend_after;
    logic             join_met;
    logic             tmo_hit;
    logic [CNT_W-1:0] tcnt_inc;
    logic [CNT_W-1:0] elapsed_inc;
    logic [3:0]       first_pick;

    // Dones count only for pending workers and never in the launch cycle.
    always_comb begin
        tracking    = (state != S_IDLE) && (state != S_FORK);
        done_hit    = tracking ? (bus.wrk_done & pend) : '0;
        pend_after  = pend & ~done_hit;
        join_met    = (mode_q == M_ANY) ? (|done_hit) : (pend_after == '0);
        tcnt_inc    = (tcnt == CNT_MAX) ? tcnt : tcnt + CNT_ONE;
        elapsed_inc = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + CNT_ONE;
        tmo_hit     = (lim_q != '0) && (tcnt_inc == lim_q);
        first_pick  = '0;
        for (int i = N_WRK - 1; i >= 0; i--) begin
            if (done_hit[i]) first_pick = 4'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mode_q        <= '0;
            en_q          <= '0;
            lim_q         <= '0;
            pend          <= '0;
            done_mask     <= '0;
            tcnt          <= '0;
            elapsed_q     <= '0;
            wrk_start_q   <= '0;
            cont_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            first_id_q    <= '0;
        end else begin
            wrk_start_q  <= '0;
            cont_start_q <= 1'b0;
            pend         <= pend_after;
            done_mask    <= done_mask | done_hit;
            if ((done_mask == '0) && (|done_hit)) first_id_q <= first_pick;

            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        mode_q        <= bus.mode;
                        en_q          <= bus.en;
                        lim_q         <= bus.timeout_lim;
                        timeout_err_q <= 1'b0;
                        elapsed_q     <= '0;
                        first_id_q    <= '0;
                        done_mask     <= '0;
                        pend          <= bus.en;
                        wrk_start_q   <= bus.en;
                        busy_q        <= 1'b1;
                        state         <= S_FORK;
                    end
                end
                S_FORK: begin
                    if ((en_q == '0) || (mode_q == M_NONE)) begin
                        cont_start_q <= 1'b1;
                        state        <= S_CONT;
                    end else begin
                        tcnt  <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    elapsed_q <= elapsed_inc;
                    // Join wins over a timeout landing on the same edge.
                    if (join_met) begin
                        cont_start_q <= 1'b1;
                        state        <= S_CONT;
                    end else if (tmo_hit) begin
                        timeout_err_q <= 1'b1;
                        pend          <= '0;
                        busy_q        <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_CONT: begin
                    state <= S_WCONT;
                end
                S_WCONT: begin
                    if (bus.cont_done) begin
                        if (pend_after == '0) begin
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            tcnt  <= '0;
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pend_after == '0) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (tmo_hit) begin
                        timeout_err_q <= 1'b1;
                        pend          <= '0;
                        busy_q        <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                default: begin
                    pend   <= '0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wrk_start   = wrk_start_q;
    assign bus.cont_start  = cont_start_q;
    assign bus.busy        = busy_q;
    assign bus.first_id    = first_id_q;
    assign bus.elapsed     = elapsed_q;
    assign bus.timeout_err = timeout_err_q;
    assign dbg_state       = state;
endmodule

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
- Hardware fork/join sequencer: on one `go` it launches a set of parallel worker units with a single-cycle start pulse, then tracks their done pulses.
- Once the join condition for the selected mode is met (join-all, join-any or join-none), it fires a single continuation job.
- Sits between a command source and a bank of independent worker engines plus one follow-on engine; reports elapsed cycles, first finisher and timeouts.

Parameters:
- N_WRK, 2, number of worker units (1..16)
- CNT_W, 16, width of elapsed and timeout counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- go  in  1  launch request; sampled only in IDLE
- mode  in  2  join mode: 00 join-all, 01 join-any, 10 join-none, 11 treated as join-all; latched on go
- en  in  N_WRK  workers to launch; latched on go
- timeout_lim  in  CNT_W  max WAIT cycles; 0 disables timeout; latched on go
- wrk_start  out  N_WRK  one-cycle start pulse per enabled worker
- wrk_done  in  N_WRK  per-worker completion pulse
- cont_start  out  1  one-cycle continuation start pulse
- cont_done  in  1  continuation completion pulse
- busy  out  1  high from the cycle after an accepted go until return to IDLE
- first_id  out  4  index of first worker to finish; valid once join reached
- elapsed  out  CNT_W  cycles from wrk_start to join condition met; saturating
- timeout_err  out  1  sticky; cleared by the next accepted go

Behaviour:
- Reset (async, rst_n=0): state=IDLE. wrk_start, cont_start, busy, first_id, elapsed, timeout_err, pend mask and done mask all 0.
- States: IDLE, FORK, WAIT, CONT, WCONT, DRAIN.
- IDLE, go=1 at edge T:
  - latch mode, en, timeout_lim; clear timeout_err, elapsed and first_id; go to FORK.
  - busy=1 from T+1.
- FORK (one cycle): wrk_start=en; pend=en; elapsed counter starts at 0.
  - en==0: no wrk_start; go to CONT regardless of mode.
  - mode=join-none: go to CONT.
  - otherwise: go to WAIT.
- WAIT: each cycle, pend &= ~wrk_done and elapsed += 1 (saturating at all-ones).
  - Join condition, join-all: pend==0.
  - Join condition, join-any: at least one enabled worker has completed.
  - first_id = lowest index among dones in the first cycle any done arrives (ties resolve to lowest index); it then holds.
  - When the join condition is met: go to CONT; elapsed freezes at its value including that cycle.
- wrk_done handling:
  - bits for workers not pending are ignored;
  - wrk_done in the same cycle as wrk_start is ignored.
- Done tracking across states: pend continues to clear on wrk_done in every non-IDLE state, including CONT, WCONT and DRAIN.
- CONT (one cycle): cont_start=1; go to WCONT.
- WCONT: wait for cont_done.
  - When cont_done arrives with pend==0: go to IDLE.
  - When cont_done arrives with pend!=0: go to DRAIN.
  - cont_done in CONT, or in the same cycle as cont_start, is ignored.
- DRAIN: wait until pend==0, then go to IDLE; busy drops the cycle IDLE is entered.
- Timeout:
  - Applies in WAIT and DRAIN only, and only when timeout_lim!=0.
  - When the cycle count in that state reaches timeout_lim: timeout_err=1, pend cleared, go to IDLE.
  - From WAIT, the continuation is skipped.
- go outside IDLE is ignored (no queuing).
- Simultaneous events:
  - A done on the same edge the timeout hits counts as a done; the join is evaluated before the timeout.
  - cont_done together with the last worker done: go straight to IDLE.
- Reset mid-operation: everything returns to reset values immediately; no pulses issued after rst_n falls.
- Outputs are registered; wrk_start and cont_start are never high for more than one cycle.

Test Plan:
- Join-any with en=2'b11, timeout_lim=0; worker0 done 20 cycles after wrk_start, worker1 after 30; cont_done 5 cycles after cont_start:
  - cont_start 1 cycle after worker0 done;
  - first_id=0, elapsed=20;
  - busy stays high until worker1 done (+1), state passes through DRAIN.
- Join-all, same latencies: cont_start 1 cycle after worker1 done; elapsed=30; first_id=0; after cont_done, IDLE next cycle with busy=0.
- Join-none, en=2'b11: cont_start the cycle after FORK, with elapsed=0; busy holds until both workers and cont_done complete.
- Tie and edge cases:
  - both done in the same cycle (join-any) -> first_id=0;
  - en=0 -> no wrk_start, cont_start 1 cycle after FORK;
  - go asserted while busy -> ignored, no extra pulses.
- Timeout: join-all, timeout_lim=10, worker1 never done:
  - timeout_err=1 after 10 WAIT cycles, IDLE, no cont_start;
  - the next go clears timeout_err.
- Async reset: rst_n low during WAIT -> all outputs 0 immediately, no cont_start afterwards; a new go after reset release works normally.
